// File: rtl/qu_decode_stage.sv
// qu_decode_stage: registered RV32I/Zicsr/Zifencei decode stage with a 2-deep output/skid buffer.
// Optional: define QU_DECODE_PERF_CNT_EN to add the perf_decoded/perf_illegal transfer counters.
module qu_decode_stage #(
    parameter int PC_WIDTH    = 12,
    parameter int INSTR_WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [INSTR_WIDTH-1:0] in_instr,
    input  logic [PC_WIDTH-1:0]    in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_WIDTH-1:0]    out_pc,
    output logic [6:0]             out_opcode,
    output logic [2:0]             out_funct3,
    output logic [4:0]             out_rd,
    output logic [4:0]             out_rs1,
    output logic [4:0]             out_rs2,
    output logic [31:0]            out_imm,
    output logic [12:0]            out_op,
    output logic                   out_illegal
`ifdef QU_DECODE_PERF_CNT_EN
    ,
    output logic [31:0]            perf_decoded,
    output logic [31:0]            perf_illegal
`endif
);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic [PC_WIDTH-1:0] pc;
        logic [6:0]          opcode;
        logic [2:0]          funct3;
        logic [4:0]          rd;
        logic [4:0]          rs1;
        logic [4:0]          rs2;
        logic [31:0]         imm;
        logic [12:0]         op;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    logic [31:0] instr;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm_i;
    logic [31:0] imm;
    logic        fmt_rd;
    logic        fmt_rs1;
    logic        fmt_rs2;
    logic        illegal;
    dec_t        dec;

    state_t      state_q;
    state_t      state_d;
    dec_t        out_q;
    dec_t        skid_q;
    logic        accept;
    logic        consume;
    logic        load_out;
    logic        load_skid;
    logic        out_from_skid;

    assign instr  = in_instr[31:0];
    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign imm_i  = {{20{instr[31]}}, instr[31:20]};

    // fmt_* describe which register fields the format carries; illegal words keep their fields
    always_comb begin
        imm     = '0;
        fmt_rd  = 1'b0;
        fmt_rs1 = 1'b0;
        fmt_rs2 = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: begin
                imm    = {instr[31:12], 12'b0};
                fmt_rd = 1'b1;
            end
            OPC_JAL: begin
                imm    = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
                fmt_rd = 1'b1;
            end
            OPC_JALR: begin
                imm     = imm_i;
                fmt_rd  = 1'b1;
                fmt_rs1 = 1'b1;
                illegal = (funct3 != 3'b000);
            end
            OPC_BRANCH: begin
                imm     = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
                fmt_rs1 = 1'b1;
                fmt_rs2 = 1'b1;
                illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
            end
            OPC_LOAD: begin
                imm     = imm_i;
                fmt_rd  = 1'b1;
                fmt_rs1 = 1'b1;
                illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
            end
            OPC_STORE: begin
                imm     = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                fmt_rs1 = 1'b1;
                fmt_rs2 = 1'b1;
                illegal = (funct3 >= 3'b011);
            end
            OPC_OP_IMM: begin
                imm     = imm_i;
                fmt_rd  = 1'b1;
                fmt_rs1 = 1'b1;
                if (funct3 == 3'b001) begin
                    illegal = (funct7 != 7'h00);
                end else if (funct3 == 3'b101) begin
                    illegal = (funct7 != 7'h00) && (funct7 != 7'h20);
                end
            end
            OPC_OP: begin
                fmt_rd  = 1'b1;
                fmt_rs1 = 1'b1;
                fmt_rs2 = 1'b1;
                illegal = !((funct7 == 7'h00) ||
                            ((funct7 == 7'h20) && ((funct3 == 3'b000) || (funct3 == 3'b101))));
            end
            OPC_FENCE: begin
                imm     = imm_i;
                fmt_rs1 = 1'b1;
                illegal = (funct3[2:1] != 2'b00);
            end
            OPC_SYSTEM: begin
                if (funct3 == 3'b000) begin
                    imm     = imm_i;
                    fmt_rs1 = 1'b1;
                    illegal = (instr[31:21] != 11'd0) || (rs1 != 5'd0) || (rd != 5'd0);
                end else begin
                    // CSR forms carry the CSR address zero-extended; funct3[2] selects the uimm variants
                    imm     = {20'b0, instr[31:20]};
                    fmt_rd  = 1'b1;
                    fmt_rs1 = !funct3[2];
                    illegal = (funct3 == 3'b100);
                end
            end
            default: illegal = 1'b1;
        endcase
        if (instr[1:0] != 2'b11) begin
            illegal = 1'b1;
        end
    end

    always_comb begin
        dec.pc     = in_pc;
        dec.opcode = opcode;
        dec.funct3 = funct3;
        dec.rd     = fmt_rd  ? rd  : 5'd0;
        dec.rs1    = fmt_rs1 ? rs1 : 5'd0;
        dec.rs2    = fmt_rs2 ? rs2 : 5'd0;
        dec.imm    = imm;
        dec.op     = {instr[30], funct3, opcode[6:2],
                      fmt_rs2 && !illegal,
                      fmt_rs1 && !illegal,
                      fmt_rd && (rd != 5'd0) && !illegal,
                      illegal};
    end

    assign in_ready  = (state_q != TWO);
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign consume   = out_valid && out_ready;

    always_comb begin
        state_d       = state_q;
        load_out      = 1'b0;
        load_skid     = 1'b0;
        out_from_skid = 1'b0;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (accept) begin
                        state_d  = ONE;
                        load_out = 1'b1;
                    end
                end
                ONE: begin
                    if (accept && consume) begin
                        load_out = 1'b1;
                    end else if (accept) begin
                        state_d   = TWO;
                        load_skid = 1'b1;
                    end else if (consume) begin
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (consume) begin
                        state_d       = ONE;
                        out_from_skid = 1'b1;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            if (load_out) begin
                out_q <= dec;
            end else if (out_from_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign out_pc      = out_q.pc;
    assign out_opcode  = out_q.opcode;
    assign out_funct3  = out_q.funct3;
    assign out_rd      = out_q.rd;
    assign out_rs1     = out_q.rs1;
    assign out_rs2     = out_q.rs2;
    assign out_imm     = out_q.imm;
    assign out_op      = out_q.op;
    assign out_illegal = out_q.op[0];

`ifdef QU_DECODE_PERF_CNT_EN
    // Counters follow the output handshake only, so a flush leaves them untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_decoded <= '0;
            perf_illegal <= '0;
        end else if (consume) begin
            perf_decoded <= perf_decoded + 32'd1;
            if (out_q.op[0]) begin
                perf_illegal <= perf_illegal + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_qu_decode_stage.sv
// tb_qu_decode_stage: randomized scoreboard bench for qu_decode_stage against a behavioural decode model.
// Also exercises the perf counters when QU_DECODE_PERF_CNT_EN is defined.
module tb_qu_decode_stage;

    typedef struct packed {
        logic [11:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] imm;
        logic [12:0] op;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [11:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_pc;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [4:0]  out_rd;
    logic [4:0]  out_rs1;
    logic [4:0]  out_rs2;
    logic [31:0] out_imm;
    logic [12:0] out_op;
    logic        out_illegal;
`ifdef QU_DECODE_PERF_CNT_EN
    logic [31:0] perf_decoded;
    logic [31:0] perf_illegal;
    int unsigned perf_dec_m;
    int unsigned perf_ill_m;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb_q[$];

    qu_decode_stage #(.PC_WIDTH(12), .INSTR_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_pc      (out_pc),
        .out_opcode  (out_opcode),
        .out_funct3  (out_funct3),
        .out_rd      (out_rd),
        .out_rs1     (out_rs1),
        .out_rs2     (out_rs2),
        .out_imm     (out_imm),
        .out_op      (out_op),
        .out_illegal (out_illegal)
`ifdef QU_DECODE_PERF_CNT_EN
        ,
        .perf_decoded(perf_decoded),
        .perf_illegal(perf_illegal)
`endif
    );

    always #5 clk = ~clk;

    // Reference decode: immediates built arithmetically from bit weights, legality from explicit lists
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [11:0] pc);
        exp_t        e;
        int          v;
        bit          has_rd, has_rs1, has_rs2, bad;
        logic [31:0] imm;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        opc = w[6:0];
        f3  = w[14:12];
        f7  = w[31:25];
        has_rd = 0; has_rs1 = 0; has_rs2 = 0; bad = 0; imm = 0; v = 0;
        case (opc)
            7'h37, 7'h17: begin imm = w & 32'hFFFF_F000; has_rd = 1; end
            7'h6F: begin
                v = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048
                    + int'(w[30:21]) * 2;
                imm = v; has_rd = 1;
            end
            7'h67: begin imm = $signed(w) >>> 20; has_rd = 1; has_rs1 = 1; bad = (f3 != 0); end
            7'h63: begin
                v = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
                imm = v; has_rs1 = 1; has_rs2 = 1; bad = f3 inside {3'd2, 3'd3};
            end
            7'h03: begin imm = $signed(w) >>> 20; has_rd = 1; has_rs1 = 1; bad = f3 inside {3'd3, 3'd6, 3'd7}; end
            7'h23: begin
                v = int'($signed(w) >>> 25) * 32 + int'(w[11:7]);
                imm = v; has_rs1 = 1; has_rs2 = 1; bad = (f3 >= 3);
            end
            7'h13: begin
                imm = $signed(w) >>> 20; has_rd = 1; has_rs1 = 1;
                if (f3 == 1) bad = (f7 != 0);
                if (f3 == 5) bad = !(f7 inside {7'h00, 7'h20});
            end
            7'h33: begin
                has_rd = 1; has_rs1 = 1; has_rs2 = 1;
                bad = !((f7 == 7'h00) || (f7 == 7'h20 && (f3 inside {3'd0, 3'd5})));
            end
            7'h0F: begin imm = $signed(w) >>> 20; has_rs1 = 1; bad = (f3 > 1); end
            7'h73: begin
                if (f3 == 0) begin
                    imm = $signed(w) >>> 20; has_rs1 = 1;
                    bad = !(w[31:20] inside {12'd0, 12'd1}) || (w[19:15] != 0) || (w[11:7] != 0);
                end else begin
                    imm = w >> 20; has_rd = 1; has_rs1 = (f3 < 4); bad = (f3 == 4);
                end
            end
            default: bad = 1;
        endcase
        e.pc     = pc;
        e.opcode = opc;
        e.funct3 = f3;
        e.rd     = has_rd  ? w[11:7]  : 5'd0;
        e.rs1    = has_rs1 ? w[19:15] : 5'd0;
        e.rs2    = has_rs2 ? w[24:20] : 5'd0;
        e.imm    = imm;
        e.op     = {w[30], f3, opc[6:2], has_rs2 && !bad, has_rs1 && !bad,
                    has_rd && (w[11:7] != 0) && !bad, bad};
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [11] = '{7'h03, 7'h0F, 7'h13, 7'h17, 7'h23, 7'h33,
                                   7'h37, 7'h63, 7'h67, 7'h6F, 7'h73};
        logic [31:0] w;
        int          sel;
        w   = $urandom();
        sel = $urandom_range(0, 13);
        if (sel < 11) begin
            w[6:0] = opcs[sel];
            if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
        end else if (sel == 11) begin
            w = ($urandom_range(0, 1) == 1) ? 32'h0010_0073 : 32'h0000_0073;
        end else if (sel == 12) begin
            w[6:0]   = 7'h33;
            w[31:25] = 7'h00;
        end
        return w;
    endfunction

    task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the scoreboard learns of an accept just after the monitor has run
    task automatic applyStimulus(input bit v, input logic [31:0] instr, input logic [11:0] pc,
                                 input bit rdy, input bit fl, output bit acc);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_instr  = instr;
        in_pc     = pc;
        out_ready = rdy;
        flush     = fl;
        @(negedge clk);
        #2;
        acc = 0;
        if (fl) begin
            sb_q.delete();
        end else if (v && in_ready) begin
            sb_q.push_back(ref_decode(instr, pc));
            acc = 1;
        end
    endtask

    task automatic sendInstr(input logic [31:0] instr, input logic [11:0] pc, input bit rdy);
        bit acc;
        acc = 0;
        for (int n = 0; n < 20 && !acc; n++) applyStimulus(1, instr, pc, rdy, 0, acc);
        if (!acc) checkOutput("send_timeout", 0, 1);
    endtask

    task automatic checkResetState(input string name);
        checkOutput({name, "_in_ready"}, in_ready, 1);
        checkOutput({name, "_outputs"}, {out_valid, out_pc, out_opcode, out_funct3, out_rd, out_rs1,
                                         out_rs2, out_imm, out_op, out_illegal}, 0);
`ifdef QU_DECODE_PERF_CNT_EN
        checkOutput({name, "_perf"}, {perf_decoded, perf_illegal}, 0);
        perf_dec_m = 0;
        perf_ill_m = 0;
`endif
    endtask

    // Monitor: status checked against scoreboard depth, data popped on each output transfer
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst_n) continue;
            checkOutput("out_valid", out_valid, sb_q.size() > 0);
            checkOutput("in_ready", in_ready, sb_q.size() < 2);
            if (out_valid && out_ready && sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checkOutput("data", {out_pc, out_opcode, out_funct3, out_rd, out_rs1, out_rs2,
                                     out_imm, out_op}, e);
                checkOutput("illegal_copy", out_illegal, e.op[0]);
`ifdef QU_DECODE_PERF_CNT_EN
                perf_dec_m++;
                if (e.op[0]) perf_ill_m++;
`endif
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bit acc;
        bit fl;
        bit rdy;
        rst_n = 0; flush = 0; in_valid = 0; in_instr = 0; in_pc = 0; out_ready = 0;
        #12;
        checkResetState("reset");
        #10 rst_n = 1;

        applyStimulus(1, 32'hFFF1_0093, 12'h100, 1, 0, acc);
        applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);
        checkOutput("addi_valid", out_valid, 1);
        checkOutput("addi_regs", {out_rd, out_rs1, out_rs2}, {5'd1, 5'd2, 5'd0});
        checkOutput("addi_imm", out_imm, 32'hFFFF_FFFF);
        checkOutput("addi_funct3", out_funct3, 0);
        checkOutput("addi_flags", out_op[3:0], 4'b0110);

        applyStimulus(1, 32'hFE20_8EE3, 12'h104, 1, 0, acc);
        applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);
        checkOutput("beq_imm", out_imm, 32'hFFFF_FFFC);
        checkOutput("beq_regs", {out_rd, out_rs1, out_rs2}, {5'd0, 5'd1, 5'd2});
        checkOutput("beq_flags", out_op[3:0], 4'b1100);

        applyStimulus(1, 32'h1234_52B7, 12'h108, 1, 0, acc);
        applyStimulus(1, 32'h0000_0000, 12'h10C, 1, 0, acc);
        checkOutput("lui_imm", out_imm, 32'h1234_5000);
        checkOutput("lui_rd", out_rd, 5);
        checkOutput("lui_flags", out_op[3:0], 4'b0010);
        applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);
        checkOutput("zero_valid", out_valid, 1);
        checkOutput("zero_illegal", {out_illegal, out_op[0]}, 2'b11);
        checkOutput("zero_imm", out_imm, 0);

        applyStimulus(1, 32'h0030_0193, 12'h200, 0, 0, acc);
        applyStimulus(1, 32'h0040_0213, 12'h204, 0, 0, acc);
        applyStimulus(1, 32'h0050_0293, 12'h208, 0, 0, acc);
        checkOutput("bp_third_held", {acc, in_ready}, 2'b00);
        sendInstr(32'h0050_0293, 12'h208, 1);
        repeat (4) applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);

        applyStimulus(1, rand_instr(), 12'h300, 0, 0, acc);
        applyStimulus(1, rand_instr(), 12'h304, 0, 0, acc);
        applyStimulus(1, rand_instr(), 12'h308, 0, 1, acc);
        applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);
        checkOutput("flush_cleared", {out_valid, in_ready}, 2'b01);
        repeat (3) applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);

        applyStimulus(1, rand_instr(), 12'h400, 0, 0, acc);
        applyStimulus(1, rand_instr(), 12'h404, 0, 0, acc);
        applyStimulus(0, 32'h0, 12'h0, 0, 0, acc);
        checkOutput("pre_reset_full", {out_valid, in_ready}, 2'b10);
        #1 rst_n = 0;
        sb_q.delete();
        #1 checkResetState("midreset");
        @(negedge clk);
        #1 rst_n = 1;

        for (int i = 0; i < 400; i++) begin
            fl  = ($urandom_range(0, 99) < 3);
            rdy = fl ? 1'b0 : ($urandom_range(0, 99) < 70);
            applyStimulus($urandom_range(0, 99) < 70, rand_instr(), 12'($urandom()), rdy, fl, acc);
        end
        repeat (6) applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);

`ifdef QU_DECODE_PERF_CNT_EN
        checkOutput("perf_random", {perf_decoded, perf_illegal}, {perf_dec_m, perf_ill_m});
        #1 rst_n = 0;
        sb_q.delete();
        #1 checkResetState("perf_reset");
        @(negedge clk);
        #1 rst_n = 1;
        sendInstr(32'hFFF1_0093, 12'h010, 1);
        sendInstr(32'hFE20_8EE3, 12'h014, 1);
        sendInstr(32'h1234_52B7, 12'h018, 1);
        sendInstr(32'h0000_0000, 12'h01C, 1);
        sendInstr(32'h0030_0193, 12'h020, 1);
        sendInstr(32'hFFFF_FFFF, 12'h024, 1);
        sendInstr(32'h0000_0073, 12'h028, 1);
        repeat (4) applyStimulus(0, 32'h0, 12'h0, 1, 0, acc);
        checkOutput("perf_decoded", perf_decoded, 7);
        checkOutput("perf_illegal", perf_illegal, 2);
        #1 rst_n = 0;
        sb_q.delete();
        #1 checkResetState("perf_clear");
        #3 rst_n = 1;
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/qu_decode_stage.md
Name: qu_decode_stage

Overview:
- Registered instruction decode stage between fetch and reservation-station dispatch.
- Accepts 32-bit RV32I instruction words plus PC over a valid/ready handshake.
- Produces split fields, a sign-extended 32-bit immediate, and a 13-bit op code matching the res_st_cell_t op field.
- Exact inverse of the team's instruction-encoding helpers; flags any word outside the supported RV32I/Zicsr/Zifencei set as illegal.

Parameters:
- PC_WIDTH, QU_PC_WIDTH (12), width of the PC carried alongside each instruction.
- INSTR_WIDTH, QU_INSTR_WIDTH (32), instruction word width; only 32 is supported.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  discard all held and incoming instructions.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  stage can accept an instruction this cycle.
- in_instr  in  32  instruction word.
- in_pc  in  PC_WIDTH  instruction address.
- out_valid  out  1  decoded instruction available.
- out_ready  in  1  dispatch consumes the instruction this cycle.
- out_pc  out  PC_WIDTH  PC of the decoded instruction.
- out_opcode  out  7  instr[6:0].
- out_funct3  out  3  instr[14:12].
- out_rd / out_rs1 / out_rs2  out  5 each  register addresses; forced to 0 when unused by the format.
- out_imm  out  32  sign-extended immediate per format; 0 for R-type.
- out_op  out  13  {instr[30], funct3, opcode[6:2], uses_rs2, uses_rs1, writes_rd, illegal}.
- out_illegal  out  1  copy of out_op[0].

Behaviour:
- Reset: out_valid=0, in_ready=1, all data outputs 0, skid entry empty.
- Structure: output register plus one skid entry (2-deep). Decode logic is combinational on in_instr; the result is registered.
- Latency: an accepted instruction appears on the outputs 1 cycle later when the outputs are empty or being consumed.
- Transfers occur when valid&&ready on each side. in_ready = !skid_valid, registered (not combinationally driven from out_ready).
- State machine: EMPTY → ONE on accept; ONE → TWO on accept without consume; TWO → ONE on consume. Any accept coinciding with a consume keeps the count. TWO never accepts.
- Ordering is FIFO: the skid entry moves into the output register on the consume edge.
- Immediate formats:
  - I-type / LOAD / JALR / SYSTEM: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U (LUI/AUIPC): {instr[31:12], 12'b0}.
  - JAL: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - CSR: csr address zero-extended.
  - FENCE: sext(instr[31:20]).
- uses_rs1 = 0 for LUI, AUIPC, JAL, CSR immediate forms.
- uses_rs2 = 1 only for R, S, B.
- writes_rd = 0 for S, B, FENCE, ECALL/EBREAK, and whenever rd==0.
- illegal is set for:
  - an unknown opcode, or instr[1:0] != 2'b11;
  - R-type funct7 not 0x00/0x20, or 0x20 with funct3 not 000/101;
  - SLLI funct7 != 0; SRLI/SRAI funct7 not 0x00/0x20;
  - LOAD funct3 011/110/111; STORE funct3 ≥ 011; BRANCH funct3 010/011; JALR funct3 != 0;
  - FENCE funct3 not 000/001;
  - SYSTEM funct3 100; SYSTEM funct3 000 with imm not 0/1 or rs1/rd != 0.
- Illegal instructions still flow through the stage; they are not dropped. All other fields decode as-is and writes_rd/uses_* are forced to 0.
- flush: both entries invalidated at the next edge. An input accepted in the flush cycle is discarded. in_ready=1 the cycle after a flush. Flush dominates a simultaneous consume.
- Reset mid-operation: all entries are dropped immediately (asynchronous). Outputs return to their reset values.

Optional Feature:
- Macro: QU_DECODE_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs perf_decoded (32) and perf_illegal (32).
  - Counters increment on each output transfer, and on each output transfer with illegal=1, respectively.
  - Counters wrap at 2^32, clear on reset, and are unaffected by flush.
- Without the macro: the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- addi x1,x2,-1 (0xFFF10093), out_ready=1 → next cycle: out_valid=1, rd=1, rs1=2, rs2=0, imm=0xFFFFFFFF, funct3=0, illegal=0, writes_rd=1.
- beq x1,x2,-4 (0xFE208EE3) → imm=0xFFFFFFFC, rs1=1, rs2=2, uses_rs2=1, writes_rd=0, rd=0.
- lui x5,0x12345 (0x123452B7) → imm=0x12345000, rd=5, uses_rs1=0; then 0x00000000 → illegal=1, out_op[0]=1, still delivered with out_valid=1.
- Backpressure: send three back-to-back instructions with out_ready=0 for 3 cycles → in_ready drops after the 2nd accept, the 3rd is held off, and all three emerge in order once out_ready=1.
- flush asserted with 2 entries held plus in_valid=1 → out_valid=0 next cycle, in_ready=1, no held instruction is ever presented.
- With QU_DECODE_PERF_CNT_EN: 5 legal plus 2 illegal transfers → perf_decoded=7, perf_illegal=2; after rst_n pulse both read 0.
